joy_adc_sequencer: RTL and testbench



---
 rtl/joy_adc_pkg.sv | 17 +
 rtl/joy_adc_sequencer_if.sv | 10 +
 rtl/joy_adc_sequencer.sv | 134 +++++++++++++
 tb/tb_joy_adc_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/joy_adc_pkg.sv
// Shared types and defaults for the joystick XADC sequencer.
package joy_adc_pkg;

  typedef enum logic [2:0] {IDLE, SETTLE, REQ, WAIT, NEXT} state_t;

  typedef enum logic [1:0] {L_X = 2'd0, L_Y = 2'd1, R_X = 2'd2, R_Y = 2'd3} slot_t;

  localparam logic [7:0]  VRX_ADDR_DEFAULT = 8'h13;
  localparam logic [7:0]  VRY_ADDR_DEFAULT = 8'h1B;
  localparam logic [11:0] CENTRE           = 12'h800;

  // Odd slots are the Y axis (VAUX11), even slots the X axis (VAUX3).
  function automatic logic [7:0] slot_addr(slot_t s, logic [7:0] vrx, logic [7:0] vry);
    return s[0] ? vry : vrx;
  endfunction

endpackage

// File: rtl/joy_adc_sequencer_if.sv
// XADC dynamic reconfiguration port, read-only subset used by the sequencer.
interface joy_adc_sequencer_if;
  logic [7:0]  drp_daddr;
  logic        drp_den;
  logic [15:0] drp_do;
  logic        drp_drdy;

  modport master (output drp_daddr, output drp_den, input drp_do, input drp_drdy);
  modport slave  (input drp_daddr, input drp_den, output drp_do, output drp_drdy);
endinterface

// File: rtl/joy_adc_sequencer.sv
// Sequences DRP reads of both joysticks through the analog mux and publishes coherent frames.
// Optional JOY_ADC_AVG_EN: four back-to-back reads per slot, truncating average stored.
module joy_adc_sequencer
  import joy_adc_pkg::*;
#(
  parameter int         SETTLE_CYCLES  = 16384,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] VRX_ADDR       = VRX_ADDR_DEFAULT,
  parameter logic [7:0] VRY_ADDR       = VRY_ADDR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  joy_adc_sequencer_if.master   drp,
  output logic                  joy_s,
  output logic [3:0][11:0]      samples,
  output logic                  frame_valid,
  output logic                  timeout_err
);

  // state  | meaning
  // IDLE   | waiting for enable
  // SETTLE | mux settling after a joy_s change
  // REQ    | one-cycle DRP read strobe for the current slot
  // WAIT   | waiting for drp_drdy, bounded by TIMEOUT_CYCLES
  // NEXT   | advance slot; mux switch after L_Y, commit after R_Y

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_nxt;
  slot_t            slot, slot_nxt;
  logic [SW-1:0]    settle_cnt;
  logic [TW-1:0]    wait_cnt;
  logic [3:0][11:0] shadow;
  logic             capture, expire, commit, last_read;
  logic [11:0]      result;
  logic             unused_lsb;

  assign unused_lsb = ^drp.drp_do[3:0];

`ifdef JOY_ADC_AVG_EN
  logic [1:0]  rep;
  logic [13:0] acc, acc_sum;
  assign acc_sum   = acc + {2'b00, drp.drp_do[15:4]};
  assign result    = acc_sum[13:2];
  assign last_read = (rep == 2'd3);
`else
  assign result    = drp.drp_do[15:4];
  assign last_read = 1'b1;
`endif

  always_comb begin
    state_nxt   = state;
    slot_nxt    = slot;
    capture     = 1'b0;
    expire      = 1'b0;
    commit      = 1'b0;
    drp.drp_den = 1'b0;
    case (state)
      IDLE:   if (enable) state_nxt = SETTLE;
      SETTLE: if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_nxt = REQ;
      REQ: begin
        drp.drp_den = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (drp.drp_drdy) begin
          capture   = 1'b1;
          state_nxt = last_read ? NEXT : REQ;
        end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          expire    = 1'b1;
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        slot_nxt = slot_t'(slot + 2'd1);
        case (slot)
          L_Y:     state_nxt = SETTLE;
          R_Y: begin
            commit    = 1'b1;
            state_nxt = enable ? SETTLE : IDLE;
          end
          default: state_nxt = REQ;
        endcase
      end
      default: state_nxt = SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SETTLE;
      slot          <= L_X;
      settle_cnt    <= '0;
      wait_cnt      <= '0;
      drp.drp_daddr <= VRX_ADDR;
      joy_s         <= 1'b0;
      shadow        <= {4{CENTRE}};
      samples       <= {4{CENTRE}};
      frame_valid   <= 1'b0;
      timeout_err   <= 1'b0;
`ifdef JOY_ADC_AVG_EN
      rep           <= '0;
      acc           <= '0;
`endif
    end else begin
      state       <= state_nxt;
      slot        <= slot_nxt;
      frame_valid <= commit;
      settle_cnt  <= (state == SETTLE && state_nxt == SETTLE) ? settle_cnt + 1'b1 : '0;
      wait_cnt    <= (state == WAIT && state_nxt == WAIT) ? wait_cnt + 1'b1 : '0;
      if (state_nxt == REQ) drp.drp_daddr <= slot_addr(slot_nxt, VRX_ADDR, VRY_ADDR);
      if (capture && last_read) shadow[slot] <= result;
      if (expire) timeout_err <= 1'b1;
      if (state == NEXT && slot == L_Y) joy_s <= 1'b1;
      if (commit) begin
        joy_s   <= 1'b0;
        samples <= shadow;
      end
`ifdef JOY_ADC_AVG_EN
      // Accumulator restarts per slot; an aborted slot lands in NEXT and is cleared too.
      if (state == NEXT) begin
        rep <= '0;
        acc <= '0;
      end else if (capture) begin
        rep <= rep + 2'd1;
        acc <= acc_sum;
      end
`endif
    end
  end

endmodule

// File: tb/tb_joy_adc_sequencer.sv
// Randomized bench for joy_adc_sequencer with a slot-level reference model and DRP responder.
module tb_joy_adc_sequencer;
  import joy_adc_pkg::*;

  localparam int SETTLE = 8;
  localparam int TMO    = 16;
  localparam int LAT    = 3;
`ifdef JOY_ADC_AVG_EN
  localparam int READS = 4;
`else
  localparam int READS = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             joy_s, frame_valid, timeout_err;
  logic [3:0][11:0] samples;

  joy_adc_sequencer_if drp();

  joy_adc_sequencer #(
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .VRX_ADDR(8'h13), .VRY_ADDR(8'h1B)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .drp(drp.master),
    .joy_s(joy_s), .samples(samples), .frame_valid(frame_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state: which slot the next read belongs to, and per-slot results
  int          cur_slot, rep, acc;
  logic [11:0] exp_shadow [4];
  logic [11:0] exp_samples[4];
  logic        exp_terr;
  int          drop_slot = -1;
  bit          fixed_mode = 1'b1;
  int          pend = 0;
  logic        pend_drop;
  logic [15:0] pend_data;
  logic        den_prev, joy_prev;
  int          since_joy;
  int          fv_count = 0;
  int          den_count = 0;

  function automatic logic [47:0] exp_packed();
    return {exp_samples[3], exp_samples[2], exp_samples[1], exp_samples[0]};
  endfunction

  always @(negedge clk) begin
    drp.drp_drdy = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0 && !pend_drop) begin
        drp.drp_drdy = 1'b1;
        drp.drp_do   = pend_data;
      end
    end
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        exp_shadow[i]  = 12'h800;
        exp_samples[i] = 12'h800;
      end
      cur_slot  = 0;
      rep       = 0;
      acc       = 0;
      exp_terr  = 1'b0;
      since_joy = 0;
      joy_prev  = 1'b0;
      den_prev  = 1'b0;
    end else begin
      if (joy_s !== joy_prev) since_joy = 0;
      else since_joy++;
      joy_prev = joy_s;
      if (drp.drp_den) begin
        den_count++;
        check("den_width", den_prev, 0);
        check("settle", since_joy >= SETTLE, 1);
        check("slot_range", cur_slot < 4, 1);
        check("daddr", drp.drp_daddr, (cur_slot % 2) ? 8'h1B : 8'h13);
        check("joy_s", joy_s, cur_slot >= 2);
        pend      = LAT;
        pend_drop = (cur_slot == drop_slot);
        pend_data = fixed_mode ? ((cur_slot % 2) ? 16'h1230 : 16'hABC0) : 16'($urandom);
        if (pend_drop) begin
          exp_terr = 1'b1;
          cur_slot++;
          rep = 0;
          acc = 0;
        end else begin
          acc += int'(pend_data[15:4]);
          rep++;
          if (rep == READS) begin
            exp_shadow[cur_slot % 4] = 12'(acc / READS);
            cur_slot++;
            rep = 0;
            acc = 0;
          end
        end
      end
      if (frame_valid) begin
        fv_count++;
        check("fv_slots", cur_slot, 4);
        for (int i = 0; i < 4; i++) exp_samples[i] = exp_shadow[i];
        check("samples", samples, exp_packed());
        check("terr", timeout_err, exp_terr);
        cur_slot = 0;
      end else begin
        check("hold", samples, exp_packed());
      end
      den_prev = drp.drp_den;
    end
  end

  task automatic wait_frames(int n, int budget);
    int target;
    int k;
    target = fv_count + n;
    k = 0;
    while (fv_count < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frame_wait", fv_count >= target, 1);
  endtask

  task automatic wait_den(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!drp.drp_den && k < 200);
    check("den_wait", drp.drp_den, 1);
  endtask

  initial begin
    logic [11:0] prev;
    int          k, dc, fc;

    repeat (3) @(negedge clk);
    check("rst_daddr", drp.drp_daddr, 8'h13);
    check("rst_den", drp.drp_den, 0);
    check("rst_joy", joy_s, 0);
    check("rst_samples", samples, 48'h800800800800);
    check("rst_fv", frame_valid, 0);
    check("rst_terr", timeout_err, 0);

    rst = 1'b0;
    enable = 1'b1;
    wait_frames(1, 400);
    check("fixed_samples", samples, 48'h123ABC123ABC);

    fixed_mode = 1'b0;
    wait_frames(3, 2000);

    prev = samples[2];
    drop_slot = 2;
    wait_frames(1, 800);
    check("to_flag", timeout_err, 1);
    check("to_keep", samples[2], prev);
    drop_slot = -1;
    wait_frames(1, 800);

    k = 0;
    while (cur_slot != 1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("reach_slot1", cur_slot, 1);
    enable = 1'b0;
    wait_frames(1, 600);
    dc = den_count;
    repeat (60) @(negedge clk);
    check("idle_no_den", den_count, dc);
    enable = 1'b1;
    wait_den(k);
    check("reen_latency", k, SETTLE + 1);
    check("reen_joy", joy_s, 0);
    wait_frames(1, 600);

    wait_den(k);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fc = fv_count;
    repeat (12) @(negedge clk);
    check("rst_wait_fv", fv_count, fc);
    check("rst_wait_samples", samples, 48'h800800800800);
    check("rst_wait_terr", timeout_err, 0);
    wait_frames(1, 600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
